// File: rtl/gsim_pkg.sv
// rtl/gsim_pkg.sv - shared sizes, banded-matrix coefficients, FSM state type and shift-add helper
package gsim_pkg;

  localparam int N     = 16;
  localparam int B_W   = 16;
  localparam int X_W   = 32;
  localparam int FRAC  = 16;
  localparam int R_W   = X_W + 6;
  localparam int TOL   = 16;

  // Band coefficients by distance from the diagonal
  localparam int COEF_D0 = 20;
  localparam int COEF_D1 = -13;
  localparam int COEF_D2 = 6;
  localparam int COEF_D3 = -1;

  typedef enum logic [1:0] {IDLE, LOAD, COMPUTE, DONE} state_t;

  // Constant multiply built only from shifts and adds; with a constant c
  // this folds to e.g. 20v = (v<<4)+(v<<2), 13v = (v<<3)+(v<<2)+v, 6v = (v<<2)+(v<<1).
  function automatic logic [R_W-1:0] cmul(input logic [R_W-1:0] v, input int c);
    logic [R_W-1:0] acc;
    int             m;
    acc = '0;
    m   = (c < 0) ? -c : c;
    for (int s = 0; s < 5; s++) begin
      if (m[s]) acc = acc + (v << s);
    end
    return (c < 0) ? -acc : acc;
  endfunction

endpackage

// File: rtl/gsim_row_eval.sv
// rtl/gsim_row_eval.sv - combinational 7-tap residual row evaluator with boundary masking
module gsim_row_eval
  import gsim_pkg::*;
(
  input  logic [3:0]       row_i,
  input  logic [7*X_W-1:0] win_i,   // tap k holds x[row-3+k]
  input  logic [B_W-1:0]   b_i,
  output logic [R_W-1:0]   r_o
);

  logic [R_W-1:0] tap [7];
  logic [R_W-1:0] b_term;

  // Sign-extend each tap and zero the ones whose column falls outside 0..N-1
  always_comb begin
    for (int k = 0; k < 7; k++) begin
      tap[k] = '0;
      if ((int'(row_i) + k >= 3) && (int'(row_i) + k <= N + 2)) begin
        tap[k] = {{(R_W-X_W){win_i[k*X_W+X_W-1]}}, win_i[k*X_W +: X_W]};
      end
    end
  end

  assign b_term = {{(R_W-B_W-FRAC){b_i[B_W-1]}}, b_i, {FRAC{1'b0}}};

  // Width R_W holds the exact sum, so modular intermediate wrap is harmless
  assign r_o = cmul(tap[3], COEF_D0)
             + cmul(tap[2] + tap[4], COEF_D1)
             + cmul(tap[1] + tap[5], COEF_D2)
             + cmul(tap[0] + tap[6], COEF_D3)
             - b_term;

endmodule

// File: rtl/gsim_residual_check.sv
// rtl/gsim_residual_check.sv - residual self-check of GSIM solution; optional sq_err via GSIM_RES_SQERR_EN
module gsim_residual_check
  import gsim_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             in_en,
  input  logic [B_W-1:0]   b_in,
  input  logic             x_valid,
  input  logic [X_W-1:0]   x_in,
  output logic             r_valid,
  output logic [3:0]       r_idx,
  output logic [R_W-1:0]   r_out,
  output logic             done,
  output logic             pass,
  output logic [63:0]      sq_err
);

  state_t         state_q, state_d;
  logic [4:0]     b_cnt_q, b_cnt_d, x_cnt_q, x_cnt_d;
  logic [4:0]     b_base, x_base;
  logic           b_wr, x_wr;
  logic [B_W-1:0] b_mem_q [N];
  logic [X_W-1:0] x_mem_q [N];
  logic [3:0]     row_q;
  logic           ok_q;
  logic           r_valid_q, done_q, pass_q;
  logic [3:0]     r_idx_q;
  logic [R_W-1:0] r_out_q;
  logic [7*X_W-1:0] win;
  logic [R_W-1:0] r_eval, r_mag;
  logic           row_ok, enter_compute;

  // Capture counters; in DONE they restart from zero so a strobe there opens a new problem
  always_comb begin
    b_base  = (state_q == DONE) ? 5'd0 : b_cnt_q;
    x_base  = (state_q == DONE) ? 5'd0 : x_cnt_q;
    b_wr    = in_en && (b_base < 5'(N));
    x_wr    = x_valid && (x_base < 5'(N));
    b_cnt_d = b_wr ? b_base + 5'd1 : b_base;
    x_cnt_d = x_wr ? x_base + 5'd1 : x_base;
  end

  // Next-state logic of the capture/compute sequencer
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_en || x_valid) state_d = LOAD;
      LOAD:    if (b_cnt_q == 5'(N) && x_cnt_q == 5'(N)) state_d = COMPUTE;
      COMPUTE: if (row_q == 4'(N-1)) state_d = DONE;
      DONE:    state_d = (in_en || x_valid) ? LOAD : IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign enter_compute = (state_q == LOAD) && (state_d == COMPUTE);

  // State and counter registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      b_cnt_q <= '0;
      x_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      b_cnt_q <= b_cnt_d;
      x_cnt_q <= x_cnt_d;
    end
  end

  // b and x register files
  always_ff @(posedge clk) begin
    if (!reset && b_wr) b_mem_q[b_base[3:0]] <= b_in;
    if (!reset && x_wr) x_mem_q[x_base[3:0]] <= x_in;
  end

  // Gather the 7-word x window around the current row; out-of-range taps are masked downstream
  always_comb begin
    win = '0;
    for (int k = 0; k < 7; k++) begin
      win[k*X_W +: X_W] = x_mem_q[4'(row_q + 4'(k) - 4'd3)];
    end
  end

  gsim_row_eval u_row_eval (
    .row_i (row_q),
    .win_i (win),
    .b_i   (b_mem_q[row_q]),
    .r_o   (r_eval)
  );

  assign r_mag  = r_eval[R_W-1] ? -r_eval : r_eval;
  assign row_ok = (r_mag <= R_W'(TOL));

  // Row sequencing, residual output registers and pass tracking
  always_ff @(posedge clk) begin
    if (reset) begin
      row_q     <= '0;
      ok_q      <= 1'b0;
      r_valid_q <= 1'b0;
      r_idx_q   <= '0;
      r_out_q   <= '0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
    end else begin
      row_q     <= (state_q == COMPUTE) ? row_q + 4'd1 : 4'd0;
      r_valid_q <= (state_q == COMPUTE);
      done_q    <= (state_q == DONE);
      if (state_q == COMPUTE) begin
        r_idx_q <= row_q;
        r_out_q <= r_eval;
        ok_q    <= ok_q & row_ok;
      end
      if (enter_compute) begin
        ok_q   <= 1'b1;
        pass_q <= 1'b0;
      end
      if (state_q == DONE) pass_q <= ok_q;
    end
  end

`ifdef GSIM_RES_SQERR_EN
  logic [63:0]      sq_q;
  logic [R_W-1:0]   out_mag;
  logic [2*R_W-1:0] sq_term;
  logic [2*R_W:0]   sq_sum;

  assign out_mag = r_out_q[R_W-1] ? -r_out_q : r_out_q;
  assign sq_term = {{R_W{1'b0}}, out_mag} * {{R_W{1'b0}}, out_mag};
  assign sq_sum  = {{(2*R_W-63){1'b0}}, sq_q} + {1'b0, sq_term};

  // Saturating sum of squared residuals over the r_valid cycles
  always_ff @(posedge clk) begin
    if (reset || enter_compute) begin
      sq_q <= '0;
    end else if (r_valid_q) begin
      sq_q <= (|sq_sum[2*R_W:64]) ? {64{1'b1}} : sq_sum[63:0];
    end
  end

  assign sq_err = sq_q;
`else
  assign sq_err = '0;
`endif

  assign r_valid = r_valid_q;
  assign r_idx   = r_idx_q;
  assign r_out   = r_out_q;
  assign done    = done_q;
  assign pass    = pass_q;

endmodule

// File: tb/tb_gsim_residual_check.sv
// tb/tb_gsim_residual_check.sv - directed self-checking bench for gsim_residual_check
module tb_gsim_residual_check;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_en = 1'b0;
  logic [15:0] b_in = '0;
  logic        x_valid = 1'b0;
  logic [31:0] x_in = '0;
  logic        r_valid;
  logic [3:0]  r_idx;
  logic [37:0] r_out;
  logic        done;
  logic        pass;
  logic [63:0] sq_err;

  int checks = 0;
  int errors = 0;

`ifdef GSIM_RES_SQERR_EN
  localparam logic [63:0] SQ_OFFSET = 64'd606;
`else
  localparam logic [63:0] SQ_OFFSET = 64'd0;
`endif

  always #5 clk = ~clk;

  gsim_residual_check dut (
    .clk     (clk),
    .reset   (reset),
    .in_en   (in_en),
    .b_in    (b_in),
    .x_valid (x_valid),
    .x_in    (x_in),
    .r_valid (r_valid),
    .r_idx   (r_idx),
    .r_out   (r_out),
    .done    (done),
    .pass    (pass),
    .sq_err  (sq_err)
  );

  logic [15:0] bv [16];
  logic [31:0] xv [16];
  logic [37:0] er [16];
  logic [37:0] rs [16];
  int          n_valid, idx_bad, first_cyc, last_cyc, done_cyc, pre_done_cnt;
  bit          got_done, done_pass, pass_first, pre_done_pass;
  logic [63:0] done_sq, pre_done_sq;

  // kind 0: all zero; 1: exact identity; 2: x0 off by one LSB; 3: negated identity
  task automatic set_problem(input int kind);
    for (int i = 0; i < 16; i++) begin
      bv[i] = '0; xv[i] = '0; er[i] = '0;
    end
    if (kind == 1 || kind == 2) begin
      bv[0] = 16'd20; bv[1] = 16'hFFF3; bv[2] = 16'd6; bv[3] = 16'hFFFF;
      xv[0] = 32'h0001_0000;
    end
    if (kind == 2) begin
      xv[0] = 32'h0001_0001;
      er[0] = 38'd20; er[1] = -38'sd13; er[2] = 38'd6; er[3] = -38'sd1;
    end
    if (kind == 3) begin
      bv[0] = 16'hFFEC; bv[1] = 16'd13; bv[2] = 16'hFFFA; bv[3] = 16'd1;
      xv[0] = 32'hFFFF_0000;
    end
  endtask

  task automatic apply_reset();
    reset = 1'b1; in_en = 1'b0; x_valid = 1'b0; b_in = '0; x_in = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // Drives b and x in parallel, one element per cycle, starting at the current negedge
  task automatic load_problem();
    pre_done_cnt = 0; pre_done_pass = 0; pre_done_sq = '0;
    for (int i = 0; i < 16; i++) begin
      in_en = 1'b1; b_in = bv[i]; x_valid = 1'b1; x_in = xv[i];
      @(negedge clk);
      if (done) begin
        pre_done_cnt++; pre_done_pass = pass; pre_done_sq = sq_err;
      end
    end
    in_en = 1'b0; x_valid = 1'b0; b_in = '0; x_in = '0;
  endtask

  task automatic collect(input bit stop_early);
    n_valid = 0; idx_bad = 0; got_done = 0; first_cyc = -1; last_cyc = -1;
    done_cyc = -1; pass_first = 0; done_pass = 0; done_sq = '0;
    for (int i = 0; i < 16; i++) rs[i] = 38'h1234;
    for (int cyc = 1; cyc <= 80; cyc++) begin
      @(negedge clk);
      if (r_valid) begin
        if (r_idx != 4'(n_valid)) idx_bad++;
        rs[r_idx] = r_out;
        if (n_valid == 0) begin
          first_cyc = cyc; pass_first = pass;
        end
        n_valid++;
        last_cyc = cyc;
      end
      if (done) begin
        got_done = 1; done_cyc = cyc; done_pass = pass; done_sq = sq_err;
        break;
      end
      if (stop_early && r_valid && r_idx == 4'd15) break;
    end
  endtask

  task automatic test_reset();
    apply_reset();
    checks++; if (r_valid !== 1'b0) begin errors++; $display("FAIL reset_r_valid got %b want 0", r_valid); end
    checks++; if (r_idx !== 4'd0) begin errors++; $display("FAIL reset_r_idx got %0d want 0", r_idx); end
    checks++; if (r_out !== 38'd0) begin errors++; $display("FAIL reset_r_out got %0h want 0", r_out); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
    checks++; if (pass !== 1'b0) begin errors++; $display("FAIL reset_pass got %b want 0", pass); end
    checks++; if (sq_err !== 64'd0) begin errors++; $display("FAIL reset_sq_err got %0d want 0", sq_err); end
  endtask

  task automatic test_zero();
    set_problem(0);
    load_problem();
    collect(0);
    checks++; if (got_done !== 1'b1) begin errors++; $display("FAIL zero_done_seen got %b want 1", got_done); end
    checks++; if (n_valid != 16) begin errors++; $display("FAIL zero_nvalid got %0d want 16", n_valid); end
    checks++; if (idx_bad != 0) begin errors++; $display("FAIL zero_idx_order got %0d bad want 0", idx_bad); end
    checks++; if (first_cyc != 2) begin errors++; $display("FAIL zero_first_latency got %0d want 2", first_cyc); end
    checks++; if (done_cyc != 18) begin errors++; $display("FAIL zero_done_latency got %0d want 18", done_cyc); end
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (rs[i] !== er[i]) begin errors++; $display("FAIL zero_r%0d got %0d want %0d", i, $signed(rs[i]), $signed(er[i])); end
    end
    checks++; if (done_pass !== 1'b1) begin errors++; $display("FAIL zero_pass got %b want 1", done_pass); end
    checks++; if (done_sq !== 64'd0) begin errors++; $display("FAIL zero_sq_err got %0d want 0", done_sq); end
    @(negedge clk);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL zero_done_pulse got %b want 0", done); end
    checks++; if (pass !== 1'b1) begin errors++; $display("FAIL zero_pass_hold got %b want 1", pass); end
  endtask

  task automatic test_identity();
    set_problem(1);
    load_problem();
    collect(0);
    checks++; if (pass_first !== 1'b0) begin errors++; $display("FAIL ident_pass_cleared got %b want 0", pass_first); end
    checks++; if (n_valid != 16) begin errors++; $display("FAIL ident_nvalid got %0d want 16", n_valid); end
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (rs[i] !== er[i]) begin errors++; $display("FAIL ident_r%0d got %0d want %0d", i, $signed(rs[i]), $signed(er[i])); end
    end
    checks++; if (got_done !== 1'b1 || done_pass !== 1'b1) begin errors++; $display("FAIL ident_pass got done=%b pass=%b want 1 1", got_done, done_pass); end
  endtask

  task automatic test_offset();
    set_problem(2);
    load_problem();
    collect(0);
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (rs[i] !== er[i]) begin errors++; $display("FAIL offset_r%0d got %0d want %0d", i, $signed(rs[i]), $signed(er[i])); end
    end
    checks++; if (got_done !== 1'b1 || done_pass !== 1'b0) begin errors++; $display("FAIL offset_pass got done=%b pass=%b want 1 0", got_done, done_pass); end
    checks++; if (done_sq !== SQ_OFFSET) begin errors++; $display("FAIL offset_sq_err got %0d want %0d", done_sq, SQ_OFFSET); end
  endtask

  task automatic test_negative();
    set_problem(3);
    load_problem();
    collect(0);
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (rs[i] !== er[i]) begin errors++; $display("FAIL neg_r%0d got %0d want %0d", i, $signed(rs[i]), $signed(er[i])); end
    end
    checks++; if (got_done !== 1'b1 || done_pass !== 1'b1) begin errors++; $display("FAIL neg_pass got done=%b pass=%b want 1 1", got_done, done_pass); end
  endtask

  task automatic test_overrun_abort();
    int  xi;
    bit  found5;
    int  late_done, late_valid;
    set_problem(1);
    xi = 0;
    // 17 b pulses with x on every other cycle, then the remaining x words
    for (int i = 0; i < 17; i++) begin
      in_en = 1'b1; b_in = (i < 16) ? bv[i] : 16'h7FFF;
      x_valid = (i % 2 == 0); x_in = xv[xi];
      if (i % 2 == 0) xi++;
      @(negedge clk);
    end
    in_en = 1'b0; b_in = '0;
    while (xi < 16) begin
      x_valid = 1'b1; x_in = xv[xi]; xi++;
      @(negedge clk);
    end
    x_valid = 1'b0; x_in = '0;
    found5 = 0;
    for (int i = 0; i < 16; i++) rs[i] = 38'h1234;
    for (int cyc = 0; cyc < 60; cyc++) begin
      @(negedge clk);
      if (r_valid) rs[r_idx] = r_out;
      if (r_valid && r_idx == 4'd5) begin
        found5 = 1; break;
      end
    end
    checks++; if (!found5) begin errors++; $display("FAIL abort_row5_seen got 0 want 1"); end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (rs[i] !== 38'd0) begin errors++; $display("FAIL abort_r%0d got %0d want 0", i, $signed(rs[i])); end
    end
    reset = 1'b1;
    @(negedge clk);
    checks++; if (r_valid !== 1'b0) begin errors++; $display("FAIL abort_r_valid got %b want 0", r_valid); end
    checks++; if (pass !== 1'b0) begin errors++; $display("FAIL abort_pass got %b want 0", pass); end
    reset = 1'b0;
    late_done = 0; late_valid = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(negedge clk);
      if (done) late_done++;
      if (r_valid) late_valid++;
    end
    checks++; if (late_done != 0) begin errors++; $display("FAIL abort_no_done got %0d pulses want 0", late_done); end
    checks++; if (late_valid != 0) begin errors++; $display("FAIL abort_no_rows got %0d rows want 0", late_valid); end
    load_problem();
    collect(0);
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (rs[i] !== er[i]) begin errors++; $display("FAIL rerun_r%0d got %0d want %0d", i, $signed(rs[i]), $signed(er[i])); end
    end
    checks++; if (got_done !== 1'b1 || done_pass !== 1'b1) begin errors++; $display("FAIL rerun_pass got done=%b pass=%b want 1 1", got_done, done_pass); end
  endtask

  task automatic test_back_to_back();
    set_problem(2);
    load_problem();
    collect(1);
    checks++; if (n_valid != 16) begin errors++; $display("FAIL b2b_first_nvalid got %0d want 16", n_valid); end
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (rs[i] !== er[i]) begin errors++; $display("FAIL b2b_first_r%0d got %0d want %0d", i, $signed(rs[i]), $signed(er[i])); end
    end
    // second problem starts in the DONE cycle of the first
    set_problem(1);
    load_problem();
    checks++; if (pre_done_cnt != 1) begin errors++; $display("FAIL b2b_first_done got %0d pulses want 1", pre_done_cnt); end
    checks++; if (pre_done_pass !== 1'b0) begin errors++; $display("FAIL b2b_first_pass got %b want 0", pre_done_pass); end
    checks++; if (pre_done_sq !== SQ_OFFSET) begin errors++; $display("FAIL b2b_first_sq got %0d want %0d", pre_done_sq, SQ_OFFSET); end
    collect(0);
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (rs[i] !== er[i]) begin errors++; $display("FAIL b2b_second_r%0d got %0d want %0d", i, $signed(rs[i]), $signed(er[i])); end
    end
    checks++; if (got_done !== 1'b1 || done_pass !== 1'b1) begin errors++; $display("FAIL b2b_second_pass got done=%b pass=%b want 1 1", got_done, done_pass); end
    checks++; if (done_sq !== 64'd0) begin errors++; $display("FAIL b2b_second_sq got %0d want 0", done_sq); end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_zero();
    test_identity();
    test_offset();
    test_negative();
    test_overrun_abort();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
